// File: rtl/mlp_layer_sequencer.sv
// Address/control sequencer for the two-layer MLP datapath: walks input and weight
// SRAM addresses, strobes MAC1/MAC2 and handshakes on their done signals.
module mlp_layer_sequencer #(
  parameter int N_IN  = 784,
  parameter int N_HID = 100,
  parameter int N_OUT = 10,
  parameter int IN_AW = 10,
  parameter int W1_AW = 18,
  parameter int W2_AW = 12,
  parameter int SEL_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             l1_only,
  input  logic             stall,
  input  logic             mac1_done,
  input  logic             mac2_done,
  output logic [IN_AW-1:0] address_3,
  output logic [W1_AW-1:0] address_1,
  output logic             mac1_en,
  output logic             mac1_start,
  output logic [SEL_W-1:0] sel,
  output logic [W2_AW-1:0] address_2,
  output logic             mac2_en,
  output logic             mac2_start,
  output logic             busy,
  output logic             done
);

  // state     | meaning
  // IDLE      | waiting for start
  // L1_RUN    | streaming one layer-1 element per cycle
  // L1_WAIT   | waiting for mac1_done on the current hidden neuron
  // L2_RUN    | streaming one layer-2 element per cycle
  // L2_WAIT   | waiting for mac2_done on the current output neuron
  // FIN       | emitting the done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_L1_RUN, S_L1_WAIT, S_L2_RUN, S_L2_WAIT, S_FIN
  } state_t;

  localparam int NW = $clog2(N_HID + 1);
  localparam int OW = $clog2(N_OUT + 1);

  state_t           state_q;
  logic             l1_only_q, pend1_q, pend2_q;
  logic [IN_AW-1:0] k_q;
  logic [NW-1:0]    n_q;
  logic [SEL_W-1:0] h_q;
  logic [OW-1:0]    o_q;
  logic [W1_AW-1:0] base1_q;
  logic [W2_AW-1:0] base2_q;

  logic [IN_AW-1:0] address_3_q;
  logic [W1_AW-1:0] address_1_q;
  logic [SEL_W-1:0] sel_q;
  logic [W2_AW-1:0] address_2_q;
  logic             mac1_en_q, mac1_start_q, mac2_en_q, mac2_start_q, busy_q, done_q;

  logic [W1_AW-1:0] address_1_d;
  logic [W2_AW-1:0] address_2_d;
  logic             mac1_go, mac2_go;

  // Neuron base addresses accumulate by the fan-in, so no multiplier is needed.
  assign address_1_d = base1_q + W1_AW'(k_q);
  assign address_2_d = base2_q + W2_AW'(h_q);
  assign mac1_go     = mac1_done | pend1_q;
  assign mac2_go     = mac2_done | pend2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      l1_only_q    <= 1'b0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      k_q          <= '0;
      n_q          <= '0;
      h_q          <= '0;
      o_q          <= '0;
      base1_q      <= '0;
      base2_q      <= '0;
      address_3_q  <= '0;
      address_1_q  <= '0;
      sel_q        <= '0;
      address_2_q  <= '0;
      mac1_en_q    <= 1'b0;
      mac1_start_q <= 1'b0;
      mac2_en_q    <= 1'b0;
      mac2_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (stall) begin
      // Everything holds; a done arriving now is remembered for the first free cycle.
      pend1_q <= pend1_q | ((state_q == S_L1_WAIT) & mac1_done);
      pend2_q <= pend2_q | ((state_q == S_L2_WAIT) & mac2_done);
    end else begin
      address_3_q  <= '0;
      address_1_q  <= '0;
      sel_q        <= '0;
      address_2_q  <= '0;
      mac1_en_q    <= 1'b0;
      mac1_start_q <= 1'b0;
      mac2_en_q    <= 1'b0;
      mac2_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          if (start) begin
            l1_only_q <= l1_only;
            k_q       <= '0;
            n_q       <= '0;
            base1_q   <= '0;
            state_q   <= S_L1_RUN;
          end
        end
        S_L1_RUN: begin
          mac1_en_q   <= 1'b1;
          address_3_q <= k_q;
          address_1_q <= address_1_d;
          if (k_q == IN_AW'(N_IN - 1)) begin
            mac1_start_q <= 1'b1;
            state_q      <= S_L1_WAIT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_L1_WAIT: begin
          if (mac1_go) begin
            pend1_q <= 1'b0;
            k_q     <= '0;
            base1_q <= base1_q + W1_AW'(N_IN);
            if (n_q == NW'(N_HID - 1)) begin
              n_q     <= '0;
              o_q     <= '0;
              h_q     <= '0;
              base2_q <= '0;
              state_q <= l1_only_q ? S_FIN : S_L2_RUN;
            end else begin
              n_q     <= n_q + 1'b1;
              state_q <= S_L1_RUN;
            end
          end
        end
        S_L2_RUN: begin
          mac2_en_q   <= 1'b1;
          sel_q       <= h_q;
          address_2_q <= address_2_d;
          if (h_q == SEL_W'(N_HID - 1)) begin
            mac2_start_q <= 1'b1;
            state_q      <= S_L2_WAIT;
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        S_L2_WAIT: begin
          if (mac2_go) begin
            pend2_q <= 1'b0;
            h_q     <= '0;
            base2_q <= base2_q + W2_AW'(N_HID);
            if (o_q == OW'(N_OUT - 1)) begin
              o_q     <= '0;
              state_q <= S_FIN;
            end else begin
              o_q     <= o_q + 1'b1;
              state_q <= S_L2_RUN;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address_3  = address_3_q;
  assign address_1  = address_1_q;
  assign mac1_en    = mac1_en_q;
  assign mac1_start = mac1_start_q;
  assign sel        = sel_q;
  assign address_2  = address_2_q;
  assign mac2_en    = mac2_en_q;
  assign mac2_start = mac2_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomised self-checking bench for mlp_layer_sequencer: a small instance against a
// queue-based element/latency model, plus a default-parameter instance for end addresses.
module tb_mlp_layer_sequencer;

  localparam int NI = 4, NH = 3, NO = 2;

  typedef struct {int a; int b; bit s;} elem_t;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, l1_only = 1'b0, stall = 1'b0;
  logic mac1_done = 1'b0, mac2_done = 1'b0;
  logic [1:0] address_3;
  logic [3:0] address_1;
  logic       mac1_en, mac1_start;
  logic [1:0] sel;
  logic [2:0] address_2;
  logic       mac2_en, mac2_start, busy, done;

  logic b_reset = 1'b0, b_start = 1'b0, b_mac1_done = 1'b0, b_mac2_done = 1'b0;
  logic [9:0]  b_address_3;
  logic [17:0] b_address_1;
  logic        b_mac1_en, b_mac1_start;
  logic [6:0]  b_sel;
  logic [11:0] b_address_2;
  logic        b_mac2_en, b_mac2_start, b_busy, b_done;

  int    cyc = 0;
  int    checks = 0, failures = 0;
  elem_t q1[$], q2[$];
  elem_t last1, last2;
  bit    active = 1'b0, l1only_m = 1'b0, big_fin = 1'b0;
  int    st_edge = 0, extra = 0, done_cyc = 0, n1s = 0, n2s = 0;

  mlp_layer_sequencer #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .IN_AW(2), .W1_AW(4),
                        .W2_AW(3), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .l1_only(l1_only), .stall(stall),
    .mac1_done(mac1_done), .mac2_done(mac2_done), .address_3(address_3),
    .address_1(address_1), .mac1_en(mac1_en), .mac1_start(mac1_start), .sel(sel),
    .address_2(address_2), .mac2_en(mac2_en), .mac2_start(mac2_start), .busy(busy),
    .done(done));

  mlp_layer_sequencer big (
    .clk(clk), .reset(b_reset), .start(b_start), .l1_only(1'b0), .stall(1'b0),
    .mac1_done(b_mac1_done), .mac2_done(b_mac2_done), .address_3(b_address_3),
    .address_1(b_address_1), .mac1_en(b_mac1_en), .mac1_start(b_mac1_start), .sel(b_sel),
    .address_2(b_address_2), .mac2_en(b_mac2_en), .mac2_start(b_mac2_start), .busy(b_busy),
    .done(b_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_zero", {address_3, address_1, mac1_en, mac1_start, sel, address_2,
                         mac2_en, mac2_start, busy, done}, 0);
      q1.delete();
      q2.delete();
      active = 1'b0;
    end else begin
      if (mac1_en) begin
        if (!stall && q1.size() == 0) chk("l1_unexpected_en", 1, 0);
        else begin
          if (!stall) begin
            last1 = q1.pop_front();
            if (last1.s) n1s++;
          end
          chk("l1_elem", {address_1, address_3, mac1_start},
              (longint'(last1.a) << 3) | (longint'(last1.b) << 1) | longint'(last1.s));
        end
      end else chk("l1_start_without_en", mac1_start, 0);
      if (mac2_en) begin
        if (!stall && q2.size() == 0) chk("l2_unexpected_en", 1, 0);
        else begin
          if (!stall) begin
            last2 = q2.pop_front();
            if (last2.s) n2s++;
          end
          chk("l2_elem", {address_2, sel, mac2_start},
              (longint'(last2.a) << 3) | (longint'(last2.b) << 1) | longint'(last2.s));
        end
      end else chk("l2_start_without_en", mac2_start, 0);
      if (done) begin
        chk("done_expected", active, 1);
        chk("done_cycle", cyc, st_edge + NH * (NI + 1) + (l1only_m ? 0 : NO * (NH + 1))
                               + extra + 1);
        chk("busy_at_done", busy, 1);
        chk("queues_drained", q1.size() + q2.size(), 0);
        done_cyc = cyc;
        active   = 1'b0;
      end else if (active && cyc >= st_edge) chk("busy_running", busy, 1);
      else if (!active) chk("busy_idle", busy, 0);
    end
  end

  // mode: 0 clean, 1 stall at address_1=5, 2 ignored-input noise, 3 reset at address_1=7,
  // 4 random done delays, stalls and noise.
  task automatic run_image(input bit l1, input int mode, output int lat);
    int pend1, pend2, scnt, d;
    bit ps, rst_flag, fin;
    pend1 = -1; pend2 = -1; scnt = 0; rst_flag = 0; fin = 0; lat = -1;
    @(negedge clk); #1;
    for (int n = 0; n < NH; n++)
      for (int k = 0; k < NI; k++) q1.push_back('{n * NI + k, k, k == NI - 1});
    if (!l1)
      for (int o = 0; o < NO; o++)
        for (int h = 0; h < NH; h++) q2.push_back('{o * NH + h, h, h == NH - 1});
    st_edge = cyc + 1; extra = 0; l1only_m = l1; n1s = 0; n2s = 0; active = 1'b1;
    start = 1'b1; l1_only = l1;
    for (int iter = 0; iter < 600 && !fin; iter++) begin
      @(negedge clk); #1;
      ps = stall;
      start = 1'b0; l1_only = 1'($urandom_range(0, 1)); stall = 1'b0;
      mac1_done = 1'b0; mac2_done = 1'b0;
      if (rst_flag) begin
        reset = 1'b1; fin = 1'b1;
      end else if (done) begin
        lat = done_cyc - st_edge + 1; fin = 1'b1;
      end else if (mode == 3 && mac1_en && address_1 == 4'd7 && !ps) begin
        reset = 1'b0; rst_flag = 1'b1;
      end else begin
        if (mac1_start && !ps) begin
          d = (mode == 4) ? int'($urandom_range(0, 2)) : 0;
          pend1 = d; extra += d;
          if (mode == 4 && d == 0 && $urandom_range(0, 2) == 0) begin
            stall = 1'b1; extra++;
          end
        end
        if (pend1 == 0) begin mac1_done = 1'b1; pend1 = -1; end
        else if (pend1 > 0) pend1--;
        if (mac2_start && !ps) begin
          d = (mode == 4) ? int'($urandom_range(0, 2)) : 0;
          pend2 = d; extra += d;
        end
        if (pend2 == 0) begin mac2_done = 1'b1; pend2 = -1; end
        else if (pend2 > 0) pend2--;
        if (mac1_en && !mac1_start) begin
          if (mode == 1 && address_1 == 4'd5 && scnt < 3) begin
            stall = 1'b1; scnt++; extra++;
          end
          if (mode == 4 && !stall && $urandom_range(0, 4) == 0) begin
            stall = 1'b1; extra++;
          end
          if ((mode == 2 || mode == 4) && $urandom_range(0, 2) == 0) begin
            mac1_done = 1'b1; mac2_done = 1'b1;
          end
        end
        if (mac2_en && !mac2_start) begin
          if (mode == 4 && $urandom_range(0, 4) == 0) begin
            stall = 1'b1; extra++;
          end
          if ((mode == 2 || mode == 4) && $urandom_range(0, 2) == 0) begin
            mac1_done = 1'b1; mac2_done = 1'b1;
          end
        end
        if ((mode == 2 || mode == 4) && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      end
    end
    if (!fin) chk("image_timeout", 0, 1);
    reset = 1'b1; start = 1'b0; stall = 1'b0; mac1_done = 1'b0; mac2_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int lat;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    run_image(1'b0, 0, lat);
    chk("lat_dual_clean", lat, 25);
    chk("mac1_start_count", n1s, 3);
    chk("mac2_start_count", n2s, 2);
    run_image(1'b1, 0, lat);
    chk("lat_l1_only", lat, 17);
    chk("l1_only_mac2_starts", n2s, 0);
    run_image(1'b0, 1, lat);
    chk("lat_stall3", lat, 28);
    run_image(1'b0, 2, lat);
    chk("lat_with_noise", lat, 25);
    run_image(1'b0, 3, lat);
    chk("reset_aborts_image", lat, -1);
    run_image(1'b0, 0, lat);
    chk("lat_after_reset", lat, 25);
    for (int i = 0; i < 10; i++) run_image(1'($urandom_range(0, 1)), 4, lat);
    wait (big_fin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : big_run
    int bst, last_a1, last_a2, n_m1s, n_m2s;
    bit fin;
    last_a1 = -1; last_a2 = -1; n_m1s = 0; n_m2s = 0; fin = 0;
    repeat (3) @(negedge clk);
    #1 b_reset = 1'b1;
    @(negedge clk); #1;
    bst = cyc + 1;
    b_start = 1'b1;
    for (int iter = 0; iter < 90000 && !fin; iter++) begin
      @(negedge clk); #1;
      b_start = 1'b0;
      b_mac1_done = b_mac1_start;
      b_mac2_done = b_mac2_start;
      if (b_mac1_en) last_a1 = int'(b_address_1);
      if (b_mac2_en) last_a2 = int'(b_address_2);
      if (b_mac1_start) n_m1s++;
      if (b_mac2_start) n_m2s++;
      if (b_done) begin
        fin = 1'b1;
        chk("big_latency", cyc - bst + 1, 1 + 100 * 785 + 10 * 101 + 1);
      end
    end
    if (!fin) chk("big_timeout", 0, 1);
    chk("big_final_address_1", last_a1, 78399);
    chk("big_final_address_2", last_a2, 999);
    chk("big_mac1_starts", n_m1s, 100);
    chk("big_mac2_starts", n_m2s, 10);
    big_fin = 1'b1;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Parametrised address/control sequencer that drives the two-layer MLP datapath in `top`: input SRAM, layer-1/layer-2 weight SRAMs, MAC1/MAC2 start strobes and the hidden-activation mux select. It replaces bench-driven address loops with an RTL state machine. It is generalised in input, hidden and output counts, and adds MAC-done handshaking, stall and single/dual-layer mode.

## Interface
Parameters:
- `N_IN`, 784, inputs per image (layer-1 fan-in)
- `N_HID`, 100, hidden neurons (layer-1 outputs, layer-2 fan-in)
- `N_OUT`, 10, output neurons
- `IN_AW`, 10, input SRAM address width (2^IN_AW ≥ N_IN)
- `W1_AW`, 18, layer-1 weight address width (2^W1_AW ≥ N_HID·N_IN)
- `W2_AW`, 12, layer-2 weight address width (2^W2_AW ≥ N_OUT·N_HID)
- `SEL_W`, 7, hidden mux select width (2^SEL_W ≥ N_HID)

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-low reset
- `start` in 1: begin one image; sampled in IDLE only
- `l1_only` in 1: sampled with `start`; 1 = skip layer 2
- `stall` in 1: freeze all counters and outputs while high
- `mac1_done` in 1: MAC1 finished current neuron
- `mac2_done` in 1: MAC2 finished current neuron
- `address_3` out IN_AW: input SRAM address
- `address_1` out W1_AW: layer-1 weight address
- `mac1_en` out 1: layer-1 element valid this cycle
- `mac1_start` out 1: last layer-1 element of current neuron
- `sel` out SEL_W: hidden activation select
- `address_2` out W2_AW: layer-2 weight address
- `mac2_en` out 1: layer-2 element valid
- `mac2_start` out 1: last layer-2 element of current neuron
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when image complete

## Operation
- States: IDLE, L1_RUN, L1_WAIT, L2_RUN, L2_WAIT, FIN.
- IDLE: `start`=1 latches `l1_only`, clears counters n, k, and goes to L1_RUN.
- L1_RUN: one element per non-stalled cycle.
  - Outputs: `address_3`=k, `address_1`=n·N_IN+k, `mac1_en`=1.
  - At k=N_IN-1, also `mac1_start`=1, then go to L1_WAIT.
- L1_WAIT: outputs idle.
  - On `mac1_done`: n+1 and k=0. If n<N_HID-1, go back to L1_RUN. Otherwise go to FIN if `l1_only`, else to L2_RUN with o=0, h=0.
- L2_RUN: `sel`=h, `address_2`=o·N_HID+h, `mac2_en`=1. At h=N_HID-1, also `mac2_start`=1, then go to L2_WAIT.
- L2_WAIT: on `mac2_done`, o+1. If o<N_OUT-1, go to L2_RUN, else to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Weight addresses come from running accumulators (base += N_IN or N_HID per neuron), not multipliers. Widths are truncated to the declared params; legal params never wrap.
- `mac*_done` outside its WAIT state is ignored; `start` outside IDLE is ignored.
- `stall` has priority over all transitions except reset. It holds every register, including the `*_en`/`*_start` pulses, which stay asserted for the stalled cycles.
- `done` and `mac*_done` arriving in a stalled cycle are not lost. The transition is taken on the first non-stalled cycle, provided the input is still high or was latched. Implementation latches `mac*_done` into a pending flag while stalled.

## Timing
- All outputs registered. Reset (`reset`=0 at a clock edge) forces IDLE and zeroes every output and counter, from any state, mid-image included.
- `start` at edge t: first element (`mac1_en`=1, addresses 0) is visible after edge t+1.
- Layer-1 neuron, unstalled: N_IN cycles of `mac1_en`, plus 1 wait cycle minimum when `mac1_done` arrives in the first L1_WAIT cycle.
- `done` is visible one cycle after the final `mac*_done` is sampled.
- `busy` falls in the same cycle `done` falls.
- Minimum image latency (`mac*_done` immediate, no stall): 1 + N_HID·(N_IN+1) + N_OUT·(N_HID+1) + 1 cycles.

## Test plan
- N_IN=4, N_HID=3, N_OUT=2, `l1_only`=0, `mac*_done` returned 1 cycle after each start -> `address_1` sequence 0..11, `address_3` 0,1,2,3 repeated; `address_2` 0..5 with `sel` 0,1,2,0,1,2; exactly 3 `mac1_start` and 2 `mac2_start`; `done` once at cycle 1+3·5+2·4+1=25.
- Same params, `l1_only`=1 -> no `mac2_en` ever; `done` at cycle 17.
- `stall` high 3 cycles while `address_1`=5 -> `address_1` stays 5 and `mac1_en` stays 1 for 4 cycles; sequence otherwise unchanged; `done` delayed by 3.
- `mac1_done` pulsed during L1_RUN and `start` pulsed mid-image -> both ignored; sequence and `done` timing unchanged.
- `reset`=0 at `address_1`=7 -> next cycle all outputs 0, IDLE; new `start` restarts from `address_1`=0.
- Default params, one image -> final `address_1`=78399 and final `address_2`=999.
